// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word_t for all 32-bit buses, fetch FSM states, IF/ID payload.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // sll $0,$0,0 -- the bubble instruction placed into IF/ID
    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
        logic  valid;
    } ifid_t;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: icache handshake, downstream control, IF/ID outputs.
//   master : the fetch stage (drives iREN/iaddr and the IF/ID register outputs)
//   slave  : icache + downstream stages (drive ihit/iload and stall/redirect/halt)
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t iload;
    logic  iREN;
    word_t iaddr;
    logic  stall;
    logic  redirect_en;
    word_t redirect_pc;
    logic  halt;
    word_t ifid_instr;
    word_t ifid_npc;
    logic  ifid_valid;

    modport master (
        input  ihit, iload, stall, redirect_en, redirect_pc, halt,
        output iREN, iaddr, ifid_instr, ifid_npc, ifid_valid
    );

    modport slave (
        output ihit, iload, stall, redirect_en, redirect_pc, halt,
        input  iREN, iaddr, ifid_instr, ifid_npc, ifid_valid
    );
endinterface

// File: rtl/fetch_stage_ifid_latch.sv
// IF/ID pipeline register with load / hold / flush controls.
//   clk, rst_n        : clock, async active-low reset (resets to bubble)
//   load              : capture {instr_in, npc_in, valid=1}
//   flush             : write the bubble {BUBBLE_INSTR, 0, 0}; wins over load
//   neither asserted  : hold
//   instr, npc, valid : registered outputs to decode
module ifid_latch #(
    parameter cpu_types_pkg::word_t BUBBLE_INSTR = cpu_types_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 flush,
    input  cpu_types_pkg::word_t instr_in,
    input  cpu_types_pkg::word_t npc_in,
    output cpu_types_pkg::word_t instr,
    output cpu_types_pkg::word_t npc,
    output logic                 valid
);
    import cpu_types_pkg::*;

    ifid_t ifid_q;

    // IF/ID storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= '{instr: BUBBLE_INSTR, npc: '0, valid: 1'b0};
        end else if (flush) begin
            ifid_q <= '{instr: BUBBLE_INSTR, npc: '0, valid: 1'b0};
        end else if (load) begin
            ifid_q <= '{instr: instr_in, npc: npc_in, valid: 1'b1};
        end
    end

    assign instr = ifid_q.instr;
    assign npc   = ifid_q.npc;
    assign valid = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the icache request, absorbs
// stall / redirect / halt, and feeds the IF/ID register.
//   CLK, nRST : clock, async active-low reset
//   fif       : fetch_stage_if.master (icache handshake, control in, IF/ID out)
// iREN/iaddr are decoded from state/pc only, so there is no path from ihit.
module fetch_stage #(
    parameter cpu_types_pkg::word_t PC_INIT   = 32'h0000_0000,
    parameter cpu_types_pkg::word_t NOP_INSTR = cpu_types_pkg::NOP_INSTR
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.master fif
);
    import cpu_types_pkg::*;

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_q, pend_d;
    word_t        target;
    word_t        pc_plus4;
    logic         ifid_load;
    logic         ifid_flush;

    assign target   = align_word(fif.redirect_pc);
    assign pc_plus4 = pc_q + PC_STEP;

    // State, PC and pending redirect target
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // Next state; priority halt > redirect > stall > normal
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (fif.halt) begin
                    ifid_flush = 1'b1;
                    state_d    = HALTED;
                end else if (fif.redirect_en) begin
                    ifid_flush = 1'b1;
                    if (fif.ihit) begin
                        pc_d = target;
                    end else begin
                        // miss still outstanding: keep iaddr, apply target on return
                        pend_d  = target;
                        state_d = DRAIN;
                    end
                end else if (fif.stall) begin
                    // hold everything; the returned word is re-requested
                end else if (fif.ihit) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                end else begin
                    ifid_flush = 1'b1;
                end
            end

            DRAIN: begin
                ifid_flush = 1'b1;
                if (fif.halt) begin
                    state_d = HALTED;
                end else begin
                    // latest redirect wins, even on the cycle the miss returns
                    if (fif.redirect_en) begin
                        pend_d = target;
                    end
                    if (fif.ihit) begin
                        pc_d    = fif.redirect_en ? target : pend_q;
                        state_d = FETCH;
                    end
                end
            end

            HALTED: begin
                ifid_flush = 1'b1;
            end

            default: begin
                ifid_flush = 1'b1;
                state_d    = HALTED;
            end
        endcase
    end

    assign fif.iREN  = (state_q != HALTED);
    assign fif.iaddr = pc_q;

    ifid_latch #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_ifid_latch (
        .clk      (CLK),
        .rst_n    (nRST),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .instr_in (fif.iload),
        .npc_in   (pc_plus4),
        .instr    (fif.ifid_instr),
        .npc      (fif.ifid_npc),
        .valid    (fif.ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a random run
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT_TB = 32'h0000_0000;

    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_fail;

    fetch_stage_if fif ();

    fetch_stage #(
        .PC_INIT   (PC_INIT_TB),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fif  (fif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural model
    word_t m_pc;
    word_t m_pend;
    bit    m_drain;
    bit    m_halt;
    word_t m_instr;
    word_t m_npc;
    bit    m_valid;

    task automatic model_reset();
        m_pc    = PC_INIT_TB;
        m_pend  = '0;
        m_drain = 0;
        m_halt  = 0;
        m_instr = '0;
        m_npc   = '0;
        m_valid = 0;
    endtask

    task automatic model_bubble();
        m_instr = '0;
        m_npc   = '0;
        m_valid = 0;
    endtask

    // One clock: drive inputs at negedge, advance the model at posedge, settle.
    task automatic tick(input bit h, input word_t w, input bit s,
                        input bit r, input word_t rp, input bit hl);
        word_t t;
        @(negedge CLK);
        fif.ihit        = h;
        fif.iload       = w;
        fif.stall       = s;
        fif.redirect_en = r;
        fif.redirect_pc = rp;
        fif.halt        = hl;
        @(posedge CLK);
        t = {rp[31:2], 2'b00};
        if (m_halt) begin
            model_bubble();
        end else if (hl) begin
            model_bubble();
            m_halt = 1;
        end else if (m_drain) begin
            model_bubble();
            if (r) m_pend = t;
            if (h) begin
                m_pc    = m_pend;
                m_drain = 0;
            end
        end else if (r) begin
            model_bubble();
            if (h) m_pc = t;
            else begin
                m_pend  = t;
                m_drain = 1;
            end
        end else if (s) begin
            // hold
        end else if (h) begin
            m_instr = w;
            m_npc   = m_pc + 32'd4;
            m_valid = 1;
            m_pc    = m_pc + 32'd4;
        end else begin
            model_bubble();
        end
        #1;
    endtask

    task automatic idle();
        fif.ihit        = 0;
        fif.iload       = '0;
        fif.stall       = 0;
        fif.redirect_en = 0;
        fif.redirect_pc = '0;
        fif.halt        = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle();
        nRST = 0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (fif.iREN !== 1'b1) begin n_fail++; $display("FAIL reset_iREN: got %b expected 1", fif.iREN); end
        n_checks++; if (fif.iaddr !== PC_INIT_TB) begin n_fail++; $display("FAIL reset_iaddr: got %h expected %h", fif.iaddr, PC_INIT_TB); end
        n_checks++; if (fif.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", fif.ifid_valid); end
        n_checks++; if (fif.ifid_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", fif.ifid_instr); end
        n_checks++; if (fif.ifid_npc !== 32'h0) begin n_fail++; $display("FAIL reset_npc: got %h expected 0", fif.ifid_npc); end
    endtask

    task automatic test_sequential();
        word_t words [3];
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        words[2] = 32'hCCCC_0003;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (fif.iaddr !== word_t'(4 * i)) begin n_fail++; $display("FAIL seq_iaddr_pre%0d: got %h expected %h", i, fif.iaddr, 4 * i); end
            tick(1, words[i], 0, 0, '0, 0);
            n_checks++; if (fif.ifid_instr !== words[i]) begin n_fail++; $display("FAIL seq_instr%0d: got %h expected %h", i, fif.ifid_instr, words[i]); end
            n_checks++; if (fif.ifid_npc !== word_t'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_npc%0d: got %h expected %h", i, fif.ifid_npc, 4 * (i + 1)); end
            n_checks++; if (fif.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b expected 1", i, fif.ifid_valid); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(1, 32'h1111_0000, 0, 0, '0, 0);
        tick(1, 32'h2222_0000, 0, 0, '0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(1, 32'hDEAD_BEEF, 1, 0, '0, 0);
            n_checks++; if (fif.iaddr !== 32'h8) begin n_fail++; $display("FAIL stall_iaddr%0d: got %h expected 00000008", i, fif.iaddr); end
            n_checks++; if (fif.ifid_npc !== 32'h8 || fif.ifid_instr !== 32'h2222_0000 || fif.ifid_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d: got %h/%h/%b expected 22220000/00000008/1", i, fif.ifid_instr, fif.ifid_npc, fif.ifid_valid);
            end
        end
        tick(1, 32'h3333_0000, 0, 0, '0, 0);
        n_checks++; if (fif.ifid_npc !== 32'hC || fif.ifid_instr !== 32'h3333_0000) begin n_fail++; $display("FAIL stall_release: got %h/%h expected 33330000/0000000c", fif.ifid_instr, fif.ifid_npc); end
    endtask

    task automatic test_redirect_hit();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, word_t'(i + 1), 0, 0, '0, 0);
        n_checks++; if (fif.iaddr !== 32'h10) begin n_fail++; $display("FAIL rdh_pre_iaddr: got %h expected 00000010", fif.iaddr); end
        tick(1, 32'hFACE_0000, 1, 1, 32'h0000_0103, 0);
        n_checks++; if (fif.iaddr !== 32'h100) begin n_fail++; $display("FAIL rdh_iaddr: got %h expected 00000100", fif.iaddr); end
        n_checks++; if (fif.ifid_valid !== 1'b0 || fif.ifid_instr !== 32'h0) begin n_fail++; $display("FAIL rdh_bubble: got %h/%b expected 00000000/0", fif.ifid_instr, fif.ifid_valid); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1, word_t'(i + 1), 0, 0, '0, 0);
        tick(0, '0, 0, 1, 32'h200, 0);
        n_checks++; if (fif.iaddr !== 32'd20) begin n_fail++; $display("FAIL drain_iaddr0: got %h expected 00000014", fif.iaddr); end
        tick(0, '0, 0, 1, 32'h300, 0);
        n_checks++; if (fif.iaddr !== 32'd20) begin n_fail++; $display("FAIL drain_iaddr1: got %h expected 00000014", fif.iaddr); end
        tick(0, '0, 0, 0, '0, 0);
        n_checks++; if (fif.iaddr !== 32'd20 || fif.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL drain_iaddr2: got %h/%b expected 00000014/0", fif.iaddr, fif.ifid_valid); end
        tick(1, 32'hBAD0_BAD0, 0, 0, '0, 0);
        n_checks++; if (fif.iaddr !== 32'h300) begin n_fail++; $display("FAIL drain_exit_iaddr: got %h expected 00000300", fif.iaddr); end
        n_checks++; if (fif.ifid_valid !== 1'b0 || fif.ifid_instr !== 32'h0) begin n_fail++; $display("FAIL drain_discard: got %h/%b expected 00000000/0", fif.ifid_instr, fif.ifid_valid); end
        // redirect arriving together with the returning miss takes effect
        tick(0, '0, 0, 1, 32'h400, 0);
        tick(1, '0, 0, 1, 32'h504, 0);
        n_checks++; if (fif.iaddr !== 32'h504) begin n_fail++; $display("FAIL drain_same_cycle: got %h expected 00000504", fif.iaddr); end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(1, '0, 0, 1, 32'hFFFF_FFFE, 0);
        n_checks++; if (fif.iaddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre: got %h expected fffffffc", fif.iaddr); end
        tick(1, 32'h1234_5678, 0, 0, '0, 0);
        n_checks++; if (fif.ifid_npc !== 32'h0 || fif.ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_npc: got %h/%b expected 00000000/1", fif.ifid_npc, fif.ifid_valid); end
        n_checks++; if (fif.iaddr !== 32'h0) begin n_fail++; $display("FAIL wrap_iaddr: got %h expected 00000000", fif.iaddr); end
    endtask

    task automatic test_halt();
        do_reset();
        tick(1, 32'h7, 0, 0, '0, 0);
        tick(1, 32'h8, 1, 1, 32'h900, 1);
        n_checks++; if (fif.iREN !== 1'b0) begin n_fail++; $display("FAIL halt_iREN: got %b expected 0", fif.iREN); end
        n_checks++; if (fif.iaddr !== 32'h4) begin n_fail++; $display("FAIL halt_pc: got %h expected 00000004", fif.iaddr); end
        n_checks++; if (fif.ifid_valid !== 1'b0) begin n_fail++; $display("FAIL halt_bubble: got %b expected 0", fif.ifid_valid); end
        for (int i = 0; i < 4; i++) tick(1, 32'h9, 0, (i % 2) == 0, 32'h40, 0);
        n_checks++; if (fif.iREN !== 1'b0 || fif.iaddr !== 32'h4 || fif.ifid_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_sticky: got %b/%h/%b expected 0/00000004/0", fif.iREN, fif.iaddr, fif.ifid_valid);
        end
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        tick(1, 32'h5, 0, 0, '0, 0);
        tick(0, '0, 0, 1, 32'h800, 0);
        @(negedge CLK);
        #1 nRST = 0;
        #1;
        model_reset();
        n_checks++; if (fif.iaddr !== PC_INIT_TB || fif.ifid_valid !== 1'b0 || fif.iREN !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_miss: got %h/%b/%b expected %h/0/1", fif.iaddr, fif.ifid_valid, fif.iREN, PC_INIT_TB);
        end
        @(negedge CLK);
        idle();
        nRST = 1;
        // pending target must be gone: a hit just advances from PC_INIT
        tick(1, 32'h6, 0, 0, '0, 0);
        n_checks++; if (fif.iaddr !== PC_INIT_TB + 32'd4) begin n_fail++; $display("FAIL rst_pend_discard: got %h expected %h", fif.iaddr, PC_INIT_TB + 32'd4); end
    endtask

    task automatic test_random();
        bit    h, s, r, hl;
        word_t w, rp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            h  = $urandom_range(0, 3) != 0;
            s  = $urandom_range(0, 5) == 0;
            r  = $urandom_range(0, 7) == 0;
            hl = $urandom_range(0, 149) == 0;
            w  = $urandom;
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | word_t'($urandom_range(0, 15))) : word_t'($urandom);
            tick(h, w, s, r, rp, hl);
            n_checks++;
            if (fif.iaddr !== m_pc || fif.iREN !== !m_halt || fif.ifid_instr !== m_instr ||
                fif.ifid_npc !== m_npc || fif.ifid_valid !== m_valid) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got iaddr=%h iREN=%b ifid=%h/%h/%b expected iaddr=%h iREN=%b ifid=%h/%h/%b",
                         i, fif.iaddr, fif.iREN, fif.ifid_instr, fif.ifid_npc, fif.ifid_valid,
                         m_pc, !m_halt, m_instr, m_npc, m_valid);
            end
            if (m_halt && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nRST     = 0;
        idle();
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_hit();
        test_redirect_drain();
        test_wrap();
        test_halt();
        test_reset_mid_miss();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
